// File: rtl/mem_cycle_ctrl.sv
// mem_cycle_ctrl: sequences one memory access at a time through a fixed
// T1..T4 beat pattern. Reads capture the shared bus at the end of T4; writes
// drive the latched write data onto the bus during T2 and T3. Writes that
// target the ROM region (addr_in[7] = 0) are rejected with a one-cycle err
// pulse and never start a bus cycle.
module mem_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr_in,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic [7:0] ar,
  output logic       ce,
  output logic       we,
  output logic       t3,
  inout  wire  [7:0] bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  logic       we_reg;    // direction of the in-flight access
  logic [7:0] wbuf;      // write data latched at acceptance
  logic       drive_en;  // registered bus output enable

  // The bus is only ever driven by this block during the T2/T3 write beats;
  // drive_en is cleared by reset, so the bus is released asynchronously.
  assign bus = drive_en ? wbuf : 8'hzz;

  // Access sequencer. Every output is registered and is loaded with the value
  // that belongs to the state being entered, so outputs line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_reg   <= 1'b0;
      wbuf     <= 8'h00;
      drive_en <= 1'b0;
      rdata    <= 8'h00;
      ar       <= 8'h00;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ce       <= 1'b0;
      we       <= 1'b0;
      t3       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge values of state and we_reg regardless of statement order.
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          ce       <= 1'b0;
          we       <= 1'b0;
          t3       <= 1'b0;
          drive_en <= 1'b0;
          busy     <= 1'b0;
          if (req) begin
            if (wr && !addr_in[7]) begin
              // ROM write: refuse it and stay idle with ar untouched.
              err <= 1'b1;
            end else begin
              ar     <= addr_in;
              we_reg <= wr;
              wbuf   <= wdata;
              state  <= T1;
              busy   <= 1'b1;
              ce     <= 1'b1;
            end
          end
        end
        T1: begin
          state    <= T2;
          busy     <= 1'b1;
          ce       <= 1'b1;
          we       <= we_reg;
          t3       <= 1'b0;
          drive_en <= we_reg;
        end
        T2: begin
          state    <= T3;
          busy     <= 1'b1;
          ce       <= 1'b1;
          we       <= we_reg;
          t3       <= 1'b1;
          drive_en <= we_reg;
        end
        T3: begin
          state    <= T4;
          busy     <= 1'b1;
          ce       <= 1'b1;
          we       <= 1'b0;
          t3       <= 1'b0;
          drive_en <= 1'b0;
        end
        T4: begin
          state    <= DONE;
          busy     <= 1'b1;
          ce       <= 1'b0;
          we       <= 1'b0;
          t3       <= 1'b0;
          drive_en <= 1'b0;
          ack      <= 1'b1;
          // The memory stage is driving the bus in T4 of a read.
          if (!we_reg) rdata <= bus;
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ce       <= 1'b0;
          we       <= 1'b0;
          t3       <= 1'b0;
          drive_en <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ce       <= 1'b0;
          we       <= 1'b0;
          t3       <= 1'b0;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Testbench for mem_cycle_ctrl: a driver issues directed and random accesses
// and queues the expected completions; a monitor on the falling edge pops the
// queue on every ack/err pulse and checks the beat pattern each cycle against
// a timeline model (offset from acceptance). A small memory model answers
// reads in T4 and stores write data on the T3 beat.
module tb_mem_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       wr;
  logic [7:0] addr_in;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       err;
  logic       busy;
  logic [7:0] ar;
  logic       ce;
  logic       we;
  logic       t3;
  wire  [7:0] bus;

  mem_cycle_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr      (wr),
    .addr_in (addr_in),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .ar      (ar),
    .ce      (ce),
    .we      (we),
    .t3      (t3),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem  [256];  // reference contents, updated on completion
  logic [7:0] phys_mem [256];  // environment memory the DUT talks to
  logic [7:0] model_ar;
  logic [7:0] model_rdata;
  int         cyc = 0;
  bit         act_valid = 1'b0;
  int         act_start = 0;
  bit         act_wr = 1'b0;
  logic [7:0] act_wdata = 8'h00;
  int         n_cmp = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory stage: stores on the T3 write beat, drives read data in T4.
  logic rd_t4;
  always @(posedge clk or posedge rst) begin
    if (rst) rd_t4 <= 1'b0;
    else begin
      rd_t4 <= t3 && !we;
      if (t3 && we) phys_mem[ar] <= bus;
    end
  end
  assign bus = (rd_t4 && ce) ? phys_mem[ar] : 8'hzz;

  // Monitor: beat pattern per cycle, completions from the scoreboard.
  int   mon_ph;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_ph = act_valid ? (cyc - act_start) : 100;
      if (ack || err) begin
        if (sb_q.size() == 0) begin
          check("spurious_ack_err", {30'd0, ack, err}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_kind", {30'd0, ack, err}, mon_e.is_err ? 32'd1 : 32'd2);
          check("pulse_cycle", cyc, mon_e.due);
          if (!mon_e.is_err) begin
            if (mon_e.is_wr) ref_mem[mon_e.addr] = mon_e.wdata;
            else model_rdata = ref_mem[mon_e.addr];
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        check("missing_pulse_cycle", cyc, sb_q[0].due);
        void'(sb_q.pop_front());
      end
      check("ce",   ce,   (mon_ph >= 0 && mon_ph <= 3) ? 32'd1 : 32'd0);
      check("we",   we,   (act_wr && (mon_ph == 1 || mon_ph == 2)) ? 32'd1 : 32'd0);
      check("t3",   t3,   (mon_ph == 2) ? 32'd1 : 32'd0);
      check("busy", busy, (mon_ph >= 0 && mon_ph <= 4) ? 32'd1 : 32'd0);
      check("ar",   ar,   model_ar);
      check("rdata", rdata, model_rdata);
      if (act_wr && (mon_ph == 1 || mon_ph == 2)) check("bus_write", bus, act_wdata);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req     = 1'b0;
      wr      = 1'($urandom);
      addr_in = 8'($urandom);
      wdata   = 8'($urandom);
    end
  endtask

  // Present one request; the edge after it is where the model says it lands.
  task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit hold_req, input bit abort);
    exp_t e;
    @(negedge clk);
    req = 1'b1; wr = w; addr_in = a; wdata = d;
    @(posedge clk);
    #1;
    e.is_wr = w; e.addr = a; e.wdata = d;
    if (w && !a[7]) begin
      e.is_err = 1'b1; e.due = cyc;
      sb_q.push_back(e);
      return;
    end
    e.is_err = 1'b0; e.due = cyc + 4;
    sb_q.push_back(e);
    model_ar  = a;
    act_start = cyc;
    act_wr    = w;
    act_wdata = d;
    act_valid = 1'b1;
    if (abort) begin
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_ce",    ce,    32'd0);
      check("rst_we",    we,    32'd0);
      check("rst_t3",    t3,    32'd0);
      check("rst_busy",  busy,  32'd0);
      check("rst_ack",   ack,   32'd0);
      check("rst_ar",    ar,    32'd0);
      check("rst_rdata", rdata, 32'd0);
      void'(sb_q.pop_back());
      model_ar    = 8'h00;
      model_rdata = 8'h00;
      act_valid   = 1'b0;
      req         = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req     = hold_req ? 1'b1 : 1'($urandom);
      wr      = 1'($urandom);
      addr_in = 8'($urandom);
      wdata   = 8'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         rw;
    logic [7:0] ra;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr_in = 8'h00; wdata = 8'h00;
    model_ar = 8'h00; model_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = 8'($urandom);
      phys_mem[i] = ref_mem[i];
    end
    ref_mem[8'h85] = 8'h3C; phys_mem[8'h85] = 8'h3C;
    #1;
    check("reset_ar",    ar,    32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_ce",    ce,    32'd0);
    check("reset_we",    we,    32'd0);
    check("reset_t3",    t3,    32'd0);
    check("reset_ack",   ack,   32'd0);
    check("reset_err",   err,   32'd0);
    check("reset_busy",  busy,  32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 8'h85, 8'h00, 1'b0, 1'b0);  // RAM read, memory returns 3C
    issue(1'b1, 8'h90, 8'hA5, 1'b0, 1'b0);  // RAM write
    issue(1'b0, 8'h90, 8'h00, 1'b0, 1'b0);  // read it back
    issue(1'b0, 8'h05, 8'h00, 1'b0, 1'b0);  // ROM read
    idle(2);
    issue(1'b1, 8'h10, 8'h77, 1'b0, 1'b0);  // ROM write, rejected
    issue(1'b0, 8'h90, 8'h00, 1'b0, 1'b0);  // accepted right after a reject
    issue(1'b1, 8'h92, 8'h5A, 1'b0, 1'b1);  // write aborted by reset in T3
    issue(1'b0, 8'h92, 8'h00, 1'b0, 1'b0);  // old contents survive the abort
    issue(1'b0, 8'h85, 8'h00, 1'b1, 1'b0);  // back-to-back, req held high
    issue(1'b0, 8'h90, 8'h00, 1'b1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      rw = 1'($urandom);
      ra = 8'($urandom);
      ra[6:3] = 4'h0;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue(rw, ra, 8'($urandom), 1'($urandom), 1'b0);
    end

    idle(10);
    check("queue_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_cycle_ctrl.md
MEM_CYCLE_CTRL -- requirements
Module: mem_cycle_ctrl

Interface
REQ-001 The block SHALL provide a single clock and an asynchronous, active-high reset; port list as below, clock and reset first.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  access request from control unit; sampled only in IDLE.
REQ-005 wr  input  1  access direction: 1 = write, 0 = read; sampled with req.
REQ-006 addr_in  input  8  access address; sampled with req.
REQ-007 wdata  input  8  write data; sampled with req.
REQ-008 rdata  output  8  read data; registered, held until the next completed read.
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 err  output  1  one-cycle pulse marking a rejected write.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ar  output  8  address register driven to the memory stage.
REQ-013 ce  output  1  memory chip enable.
REQ-014 we  output  1  memory write enable (1 = write beat).
REQ-015 t3  output  1  memory strobe beat.
REQ-016 bus  inout  8  shared data bus; driven only during write beats, otherwise high-Z.

Function
REQ-017 The FSM SHALL use the states IDLE, T1, T2, T3, T4, DONE, all fully decoded, with unused encodings returning to IDLE.
REQ-018 IDLE with req=1, accepted and not rejected: latch addr_in->ar, wr->we_reg, wdata->wbuf; next state T1.
REQ-019 IDLE with req=1, wr=1, addr_in[7]=0 (ROM region): reject, no bus cycle, err=1 for the next cycle, stay in IDLE, ar unchanged.
REQ-020 IDLE with req=0: hold; ce=we=t3=0.
REQ-021 T1: ce=1, we=0, t3=0; next T2.
REQ-022 T2: ce=1, we=we_reg, t3=0; for writes bus=wbuf; next T3.
REQ-023 T3: ce=1, we=we_reg, t3=1; for writes bus=wbuf; next T4.
REQ-024 T4: ce=1, we=0, t3=0, bus high-Z; for reads, rdata<=bus at the rising edge leaving T4; next DONE.
REQ-025 DONE: ack=1, ce=0, busy=1; next IDLE unconditionally.
REQ-026 Latency: request accepted at edge k -> ack high in cycle k+5, with rdata valid in that same cycle.
REQ-027 The next request SHALL be acceptable in the cycle after DONE, giving a 6-cycle minimum issue interval.
REQ-028 req, wr, addr_in and wdata changes while busy=1 SHALL be ignored; the in-flight access completes with its latched values.
REQ-029 bus SHALL never be driven in IDLE, T1, T4 or DONE, or during any read access.
REQ-030 ar SHALL hold its last value in IDLE, T1 through T4 and DONE; it changes only on acceptance.
REQ-031 rdata SHALL be unchanged by write accesses and rejected requests.
REQ-032 ack and err SHALL never be high in the same cycle.

Reset
REQ-033 rst=1 SHALL force IDLE immediately without waiting for clk.
REQ-034 While rst=1, ar=0, rdata=0, ce=we=t3=0, ack=err=busy=0, and bus is high-Z.
REQ-035 Reset mid-access SHALL abort the access with no ack, and bus SHALL be released in the same cycle.
REQ-036 After rst falls, the first request SHALL be accepted on the first clk edge at which req=1.

Verification
REQ-037 Read RAM: req=1, wr=0, addr_in=8'h85; memory returns 8'h3C -> ce=1 for T1 through T4, t3 high exactly in T3, ack in cycle k+5, rdata=8'h3C.
REQ-038 Write RAM: req=1, wr=1, addr_in=8'h90, wdata=8'hA5 -> bus=8'hA5 in T2 and T3 only, we=1 in T2 and T3, ack once, and a subsequent read of 8'h90 returns 8'hA5.
REQ-039 Read ROM: addr_in=8'h05 -> ack in cycle k+5, rdata equals the ROM word, and bus is not driven by this block at any point.
REQ-040 Rejected write: wr=1, addr_in=8'h10 -> err pulses for 1 cycle, busy stays 0, ce stays 0, no ack, and ar is unchanged.
REQ-041 Reset in T3 of a write: assert rst -> bus goes high-Z and ce, we, t3 go to 0 asynchronously, no ack is produced, and the next read is correct.
REQ-042 Back-to-back with req held high: two reads are issued 6 cycles apart, exactly 2 ack pulses occur, and address changes made while busy are ignored.
